// File: rtl/flip_walk_engine_pkg.sv
// Shared types and cell codes for the reversi flip walk engine.
// Optional feature macro: FLIP_COUNT_EN (adds the flip_count output).
package reversi_pkg;

    typedef enum logic [2:0] {
        DIR_UP         = 3'b000,
        DIR_DOWN       = 3'b001,
        DIR_LEFT       = 3'b010,
        DIR_RIGHT      = 3'b011,
        DIR_UP_LEFT    = 3'b100,
        DIR_DOWN_LEFT  = 3'b101,
        DIR_UP_RIGHT   = 3'b110,
        DIR_DOWN_RIGHT = 3'b111
    } dir_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WALK = 2'd1,
        DONE = 2'd2
    } fsm_t;

    localparam logic [1:0] CELL_BLACK = 2'b11;
    localparam logic [1:0] CELL_WHITE = 2'b10;

    function automatic logic [1:0] player_code(input logic black);
        return black ? CELL_BLACK : CELL_WHITE;
    endfunction

endpackage

// File: rtl/flip_walk_engine_if.sv
// Request/result bundle between the move validator, the flip engine and the board register.
// flip_count is present only when FLIP_COUNT_EN is defined.
interface flip_walk_if
    import reversi_pkg::*;
#(
    parameter int BOARD_DIM = 8,
    parameter int CELL_W    = 2
) ();
    localparam int COORD_W = $clog2(BOARD_DIM);
    localparam int BOARD_W = BOARD_DIM * BOARD_DIM * CELL_W;

    logic                   start;
    logic [COORD_W-1:0]     x;
    logic [COORD_W-1:0]     y;
    logic [2*COORD_W-1:0]   end_point;
    dir_t                   direction;
    logic [BOARD_W-1:0]     board;
    logic                   player_black;
    logic                   busy;
    logic                   done;
    logic                   err;
    logic [BOARD_W-1:0]     result_board;
`ifdef FLIP_COUNT_EN
    logic [COORD_W:0]       flip_count;
`endif

    modport master (
        output start, x, y, end_point, direction, board, player_black,
        input  busy, done, err, result_board
`ifdef FLIP_COUNT_EN
        , input flip_count
`endif
    );

    modport slave (
        input  start, x, y, end_point, direction, board, player_black,
        output busy, done, err, result_board
`ifdef FLIP_COUNT_EN
        , output flip_count
`endif
    );

endinterface

// File: rtl/flip_walk_engine_step_gen.sv
// Combinational geometry check: derives the unit step, walk length and validity of a
// request from the placed cell, the end point and the requested direction.
module flip_step_gen
    import reversi_pkg::*;
#(
    parameter int COORD_W = 3
) (
    input  logic [COORD_W-1:0]   x,
    input  logic [COORD_W-1:0]   y,
    input  logic [2*COORD_W-1:0] end_point,
    input  dir_t                 direction,
    output logic signed [1:0]    sx,
    output logic signed [1:0]    sy,
    output logic [COORD_W-1:0]   d,
    output logic                 valid
);
    localparam logic signed [1:0] STEP_NEG  = -2'sd1;
    localparam logic signed [1:0] STEP_POS  = 2'sd1;
    localparam logic signed [1:0] STEP_ZERO = 2'sd0;

    logic [COORD_W-1:0]      end_x, end_y;
    logic signed [COORD_W:0] dx, dy;
    logic [COORD_W-1:0]      adx, ady;
    logic                    dx_neg, dx_pos, dx_zero;
    logic                    dy_neg, dy_pos, dy_zero;
    logic                    diag_eq;

    assign end_x = end_point[COORD_W-1:0];
    assign end_y = end_point[2*COORD_W-1:COORD_W];

    // One extra bit keeps the signed difference of two unsigned coordinates exact.
    assign dx = $signed({1'b0, end_x}) - $signed({1'b0, x});
    assign dy = $signed({1'b0, end_y}) - $signed({1'b0, y});

    assign adx = dx[COORD_W] ? COORD_W'(-dx) : dx[COORD_W-1:0];
    assign ady = dy[COORD_W] ? COORD_W'(-dy) : dy[COORD_W-1:0];

    assign dx_zero = (dx == '0);
    assign dy_zero = (dy == '0);
    assign dx_neg  = dx[COORD_W];
    assign dy_neg  = dy[COORD_W];
    assign dx_pos  = !dx_neg && !dx_zero;
    assign dy_pos  = !dy_neg && !dy_zero;
    assign diag_eq = (adx == ady);

    always_comb begin
        sx    = STEP_ZERO;
        sy    = STEP_ZERO;
        d     = adx;
        valid = 1'b0;
        case (direction)
            DIR_UP: begin
                sy    = STEP_NEG;
                d     = ady;
                valid = dy_neg && dx_zero;
            end
            DIR_DOWN: begin
                sy    = STEP_POS;
                d     = ady;
                valid = dy_pos && dx_zero;
            end
            DIR_LEFT: begin
                sx    = STEP_NEG;
                valid = dx_neg && dy_zero;
            end
            DIR_RIGHT: begin
                sx    = STEP_POS;
                valid = dx_pos && dy_zero;
            end
            DIR_UP_LEFT: begin
                sx    = STEP_NEG;
                sy    = STEP_NEG;
                valid = dx_neg && dy_neg && diag_eq;
            end
            DIR_DOWN_LEFT: begin
                sx    = STEP_NEG;
                sy    = STEP_POS;
                valid = dx_neg && dy_pos && diag_eq;
            end
            DIR_UP_RIGHT: begin
                sx    = STEP_POS;
                sy    = STEP_NEG;
                valid = dx_pos && dy_neg && diag_eq;
            end
            DIR_DOWN_RIGHT: begin
                sx    = STEP_POS;
                sy    = STEP_POS;
                valid = dx_pos && dy_pos && diag_eq;
            end
            default: valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/flip_walk_engine.sv
// Reversi flip engine: copies the source board, then paints one cell per clock from the
// placed cell toward the end point. Define FLIP_COUNT_EN to add the flipped-cell counter.
module flip_walk_engine
    import reversi_pkg::*;
#(
    parameter int BOARD_DIM = 8,
    parameter int CELL_W    = 2
) (
    input  logic        clk,
    input  logic        resetn,
    flip_walk_if.slave  bus
);
    localparam int COORD_W = $clog2(BOARD_DIM);
    localparam int BOARD_W = BOARD_DIM * BOARD_DIM * CELL_W;
    localparam int IDX_W   = $clog2(BOARD_W);

    fsm_t                state_q, state_d;
    logic [COORD_W-1:0]  cur_x_q, cur_y_q;
    logic [COORD_W-1:0]  rem_q;
    logic signed [1:0]   sx_q, sy_q;
    logic [CELL_W-1:0]   code_q;
    logic [BOARD_W-1:0]  result_q;
    logic                err_q;

    logic signed [1:0]   step_sx, step_sy;
    logic [COORD_W-1:0]  step_d;
    logic                step_valid;
    logic                accept;
    logic                last_write;
    logic [IDX_W-1:0]    bit_idx;

    flip_step_gen #(
        .COORD_W (COORD_W)
    ) u_step_gen (
        .x         (bus.x),
        .y         (bus.y),
        .end_point (bus.end_point),
        .direction (bus.direction),
        .sx        (step_sx),
        .sy        (step_sy),
        .d         (step_d),
        .valid     (step_valid)
    );

    assign accept     = bus.start && ((state_q == IDLE) || (state_q == DONE));
    assign last_write = (rem_q == COORD_W'(1));
    // BOARD_DIM is a power of two, so {cy,cx} is already the linear cell number.
    assign bit_idx    = IDX_W'({cur_y_q, cur_x_q}) * IDX_W'(CELL_W);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (bus.start) state_d = step_valid ? WALK : DONE;
            WALK: if (last_write) state_d = DONE;
            DONE: begin
                if (bus.start) state_d = step_valid ? WALK : DONE;
                else           state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.busy         = (state_q == WALK);
        bus.done         = (state_q == DONE);
        bus.err          = err_q;
        bus.result_board = result_q;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cur_x_q  <= '0;
            cur_y_q  <= '0;
            rem_q    <= '0;
            sx_q     <= '0;
            sy_q     <= '0;
            code_q   <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else if (accept) begin
            cur_x_q  <= bus.x;
            cur_y_q  <= bus.y;
            rem_q    <= step_d;
            sx_q     <= step_sx;
            sy_q     <= step_sy;
            code_q   <= CELL_W'(player_code(bus.player_black));
            result_q <= bus.board;
            err_q    <= !step_valid;
        end else if (state_q == WALK) begin
            result_q[bit_idx +: CELL_W] <= code_q;
            cur_x_q <= cur_x_q + COORD_W'(sx_q);
            cur_y_q <= cur_y_q + COORD_W'(sy_q);
            rem_q   <= rem_q - COORD_W'(1);
        end
    end

`ifdef FLIP_COUNT_EN
    logic [COORD_W:0]    flip_q;
    logic                first_q;
    logic [CELL_W-1:0]   opp_code;

    // Opponent code differs from ours only in the colour bit.
    assign opp_code       = code_q ^ CELL_W'(1);
    assign bus.flip_count = flip_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            flip_q  <= '0;
            first_q <= 1'b0;
        end else if (accept) begin
            flip_q  <= '0;
            first_q <= 1'b1;
        end else if (state_q == WALK) begin
            first_q <= 1'b0;
            if (!first_q && (result_q[bit_idx +: CELL_W] == opp_code))
                flip_q <= flip_q + (COORD_W+1)'(1);
        end
    end
`endif

endmodule

// File: tb/tb_flip_walk_engine.sv
// Directed self-checking bench for flip_walk_engine on an 8x8 board.
module tb_flip_walk_engine;
    import reversi_pkg::*;

    localparam int DIM = 8;
    localparam int BW  = DIM * DIM * 2;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    flip_walk_if #(.BOARD_DIM(DIM), .CELL_W(2)) bus ();

    flip_walk_engine #(.BOARD_DIM(DIM), .CELL_W(2)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [BW-1:0] setc(input logic [BW-1:0] b, input int cx, input int cy,
                                           input logic [1:0] v);
        logic [BW-1:0] r;
        r = b;
        r[(cy*DIM+cx)*2 +: 2] = v;
        return r;
    endfunction

    task automatic drive(input int x, input int y, input int ex, input int ey, input dir_t dir,
                         input logic black, input logic [BW-1:0] brd);
        bus.x            = 3'(x);
        bus.y            = 3'(y);
        bus.end_point    = {3'(ey), 3'(ex)};
        bus.direction    = dir;
        bus.player_black = black;
        bus.board        = brd;
        bus.start        = 1'b1;
    endtask

    task automatic accept_req(input int x, input int y, input int ex, input int ey, input dir_t dir,
                              input logic black, input logic [BW-1:0] brd);
        drive(x, y, ex, ey, dir, black, brd);
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(output int nbusy, output int nwait);
        nbusy = 0;
        nwait = 0;
        while (bus.done !== 1'b1 && nwait < 64) begin
            if (bus.busy === 1'b1) nbusy++;
            @(posedge clk); #1;
            nwait++;
        end
        chk("done_seen", BW'(bus.done), BW'(1));
    endtask

    logic [BW-1:0] all_white, all_black, mixed, exp_b;
    int nb, nw;

    initial begin
        all_white = {(DIM*DIM){CELL_WHITE}};
        all_black = {(DIM*DIM){CELL_BLACK}};
        mixed     = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
        bus.start = 1'b0;
        drive(0, 0, 0, 0, DIR_UP, 1'b0, '0);
        bus.start = 1'b0;

        // Reset state
        #12;
        chk("rst_busy", BW'(bus.busy), '0);
        chk("rst_done", BW'(bus.done), '0);
        chk("rst_err", BW'(bus.err), '0);
        chk("rst_board", bus.result_board, '0);
`ifdef FLIP_COUNT_EN
        chk("rst_flip", BW'(bus.flip_count), '0);
`endif
        @(negedge clk) resetn = 1'b1;
        @(posedge clk); #1;

        // Right walk: (2..5,3) black, (6,3) untouched
        exp_b = all_white;
        for (int cx = 2; cx <= 5; cx++) exp_b = setc(exp_b, cx, 3, CELL_BLACK);
        accept_req(2, 3, 6, 3, DIR_RIGHT, 1'b1, all_white);
        wait_done(nb, nw);
        chk("right_busy_cycles", BW'(nb), BW'(4));
        chk("right_latency", BW'(nw), BW'(4));
        chk("right_err", BW'(bus.err), '0);
        chk("right_board", bus.result_board, exp_b);
        @(posedge clk); #1;
        chk("right_done_pulse", BW'(bus.done), '0);

        // Up-left walk from (5,5) toward (2,2)
        exp_b = all_white;
        for (int i = 3; i <= 5; i++) exp_b = setc(exp_b, i, i, CELL_BLACK);
        accept_req(5, 5, 2, 2, DIR_UP_LEFT, 1'b1, all_white);
        wait_done(nb, nw);
        chk("upleft_busy_cycles", BW'(nb), BW'(3));
        chk("upleft_board", bus.result_board, exp_b);
        chk("upleft_err", BW'(bus.err), '0);
        @(posedge clk); #1;

        // Invalid: not on the down-right diagonal
        accept_req(3, 3, 5, 4, DIR_DOWN_RIGHT, 1'b1, mixed);
        chk("inv_done_next", BW'(bus.done), BW'(1));
        chk("inv_busy", BW'(bus.busy), '0);
        chk("inv_err", BW'(bus.err), BW'(1));
        chk("inv_board", bus.result_board, mixed);
        @(posedge clk); #1;

        // Invalid: end point equals placed cell
        accept_req(4, 4, 4, 4, DIR_RIGHT, 1'b0, all_white);
        chk("zero_len_done", BW'(bus.done), BW'(1));
        chk("zero_len_err", BW'(bus.err), BW'(1));
        chk("zero_len_board", bus.result_board, all_white);
        @(posedge clk); #1;

        // Back-to-back with an ignored start during busy
        exp_b = all_black;
        for (int cx = 0; cx <= 2; cx++) exp_b = setc(exp_b, cx, 0, CELL_WHITE);
        accept_req(0, 0, 3, 0, DIR_RIGHT, 1'b0, all_black);
        drive(4, 7, 7, 7, DIR_RIGHT, 1'b1, all_white);
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_done(nb, nw);
        chk("b2b_first_rest", BW'(nb), BW'(2));
        chk("b2b_first_board", bus.result_board, exp_b);
        exp_b = all_white;
        exp_b = setc(exp_b, 7, 7, CELL_BLACK);
        exp_b = setc(exp_b, 7, 6, CELL_BLACK);
        accept_req(7, 7, 7, 5, DIR_UP, 1'b1, all_white);
        chk("b2b_second_busy", BW'(bus.busy), BW'(1));
        chk("b2b_second_no_done", BW'(bus.done), '0);
        wait_done(nb, nw);
        chk("b2b_second_cycles", BW'(nb), BW'(2));
        chk("b2b_second_board", bus.result_board, exp_b);
        @(posedge clk); #1;

        // Reset in the middle of a walk
        accept_req(2, 3, 6, 3, DIR_RIGHT, 1'b1, all_white);
        @(posedge clk); #1;
        resetn = 1'b0;
        #1;
        chk("midrst_busy", BW'(bus.busy), '0);
        chk("midrst_done", BW'(bus.done), '0);
        chk("midrst_board", bus.result_board, '0);
        @(negedge clk) resetn = 1'b1;
        @(posedge clk); #1;
        exp_b = all_white;
        for (int cx = 2; cx <= 5; cx++) exp_b = setc(exp_b, cx, 3, CELL_BLACK);
        accept_req(2, 3, 6, 3, DIR_RIGHT, 1'b1, all_white);
        wait_done(nb, nw);
        chk("postrst_cycles", BW'(nb), BW'(4));
        chk("postrst_board", bus.result_board, exp_b);
        @(posedge clk); #1;

`ifdef FLIP_COUNT_EN
        // Full diagonal, white player; placed (0,0) black is not counted
        mixed = all_white;
        mixed = setc(mixed, 0, 0, CELL_BLACK);
        mixed = setc(mixed, 1, 1, CELL_BLACK);
        mixed = setc(mixed, 3, 3, CELL_BLACK);
        mixed = setc(mixed, 6, 6, CELL_BLACK);
        mixed = setc(mixed, 7, 7, CELL_BLACK);
        exp_b = setc(all_white, 7, 7, CELL_BLACK);
        accept_req(0, 0, 7, 7, DIR_DOWN_RIGHT, 1'b0, mixed);
        wait_done(nb, nw);
        chk("flip_cycles", BW'(nb), BW'(7));
        chk("flip_board", bus.result_board, exp_b);
        chk("flip_count", BW'(bus.flip_count), BW'(3));
        @(posedge clk); #1;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
